// File: rtl/smg_pkg.sv
// ============================================================================
// smg_pkg : shared constants and FSM state type for the BCD display path
// Revision: 1.0
// ============================================================================
`default_nettype none

package smg_pkg;

    localparam int BCD_DIGITS   = 4;
    localparam int SAT_VAL_DFLT = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_adj3.sv
// ============================================================================
// bcd_adj3 : combinational double-dabble cell, adds 3 to a BCD digit >= 5
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_adj3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_smg.sv
// ============================================================================
// bin2bcd_smg : iterative binary-to-BCD converter feeding the 4-digit display
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_smg
    import smg_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int SAT_VAL = SAT_VAL_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    output logic [15:0]      out_bcd,
    output logic             out_valid,
    output logic             ovf,
    output logic             busy
);

    localparam int c_CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int c_WORK_W = 16 + BIN_W;

    state_t               r_state;
    logic [c_WORK_W-1:0]  r_work;      // {bcd accumulator, binary shift register}
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_next;

    logic [15:0]          w_bcd_adj;
    logic [c_WORK_W-1:0]  w_work_next;
    logic                 w_accept;
    logic                 w_over;
    logic [BIN_W-1:0]     w_load;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            bcd_adj3 u_adj (
                .d (r_work[BIN_W + 4*gi +: 4]),
                .q (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // The clamp keeps digit3 <= 9, so the bit shifted out of the top is always 0.
    assign w_work_next = {w_bcd_adj, r_work[BIN_W-1:0]} << 1;

    assign w_accept = in_valid && in_ready;
    assign w_over   = 32'(in_bin) > 32'(SAT_VAL);
    assign w_load   = w_over ? BIN_W'(SAT_VAL) : in_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            out_bcd    <= 16'h0000;
            out_valid  <= 1'b0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_work     <= {16'h0000, w_load};
                        r_ovf_next <= w_over;
                        r_cnt      <= c_CNT_W'(BIN_W - 1);
                        r_state    <= SHIFT;
                        busy       <= 1'b1;
                        in_ready   <= 1'b0;
                    end else begin
                        r_state    <= IDLE;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        out_bcd   <= w_work_next[c_WORK_W-1:BIN_W];
                        ovf       <= r_ovf_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
